btn_cmd_conditioner: RTL

- Front-end stage directly upstream of the mod-M up/down counter.
- Synchronises and debounces four raw push-button inputs: increment, decrement, load, clear.
- Converts button presses into single-cycle command pulses on the counter's control inputs: en, up, load, syn_clear.
- Increment and decrement support hold-to-auto-repeat.

---
 rtl/btn_cmd_conditioner_pkg.sv | 41 ++++
 rtl/btn_cmd_conditioner_if.sv | 16 +
 rtl/btn_cmd_conditioner_debounce.sv | 108 ++++++++++
 rtl/btn_cmd_conditioner.sv | 63 ++++++
 4 files changed

// File: rtl/btn_cmd_conditioner_pkg.sv
// rtl/btn_cmd_conditioner_pkg.sv - shared encodings and command arbitration for the button front-end
package btn_cmd_conditioner_pkg;

    typedef enum logic [1:0] {
        DB_RELEASED  = 2'd0,
        DB_ARMING    = 2'd1,
        DB_PRESSED   = 2'd2,
        DB_DISARMING = 2'd3
    } db_state_t;

    localparam int CMD_CLR  = 0;
    localparam int CMD_LOAD = 1;
    localparam int CMD_INC  = 2;
    localparam int CMD_DEC  = 3;
    localparam int CMD_NUM  = 4;

    typedef struct packed {
        logic en;
        logic up;
        logic load;
        logic syn_clear;
    } cmd_t;

    // Lower-priority events in the same cycle are dropped; inc+dec together cancel out.
    function automatic cmd_t arbitrate(input logic [CMD_NUM-1:0] evt);
        cmd_t c;
        c = '{en: 1'b0, up: 1'b1, load: 1'b0, syn_clear: 1'b0};
        if (evt[CMD_CLR]) begin
            c.en        = 1'b1;
            c.syn_clear = 1'b1;
        end else if (evt[CMD_LOAD]) begin
            c.en   = 1'b1;
            c.load = 1'b1;
        end else if (evt[CMD_INC] ^ evt[CMD_DEC]) begin
            c.en = 1'b1;
            c.up = evt[CMD_INC];
        end
        return c;
    endfunction

endpackage

// File: rtl/btn_cmd_conditioner_if.sv
// rtl/btn_cmd_conditioner_if.sv - raw buttons in, counter command pulses out
interface btn_cmd_conditioner_if;
    logic btn_inc;
    logic btn_dec;
    logic btn_load;
    logic btn_clr;
    logic en;
    logic up;
    logic load;
    logic syn_clear;

    modport master (output btn_inc, btn_dec, btn_load, btn_clr,
                    input  en, up, load, syn_clear);
    modport slave  (input  btn_inc, btn_dec, btn_load, btn_clr,
                    output en, up, load, syn_clear);
endinterface

// File: rtl/btn_cmd_conditioner_debounce.sv
// rtl/btn_cmd_conditioner_debounce.sv - one button: 2-flop sync, debounce FSM, optional auto-repeat
module btn_debounce
    import btn_cmd_conditioner_pkg::*;
#(
    parameter int DB_CYCLES  = 16,
    parameter int DB_W       = 5,
    parameter int REP_DELAY  = 1024,
    parameter int REP_PERIOD = 256,
    parameter int REP_W      = 11,
    parameter bit REPEAT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pressed,
    output logic evt
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1;
    logic            s;
    db_state_t       state, state_next;
    logic [DB_W-1:0] cnt, cnt_next;
    logic            press_evt;
    logic            rep_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DB_RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DB_RELEASED: if (s) begin
                state_next = DB_ARMING;
                cnt_next   = DB_W'(1);
            end
            DB_ARMING: begin
                if (!s)                  state_next = DB_RELEASED;
                else if (cnt == DB_LAST) state_next = DB_PRESSED;
                else                     cnt_next   = cnt + 1'b1;
            end
            DB_PRESSED: if (!s) begin
                state_next = DB_DISARMING;
                cnt_next   = DB_W'(1);
            end
            DB_DISARMING: begin
                if (s)                   state_next = DB_PRESSED;
                else if (cnt == DB_LAST) state_next = DB_RELEASED;
                else                     cnt_next   = cnt + 1'b1;
            end
            default: state_next = DB_RELEASED;
        endcase
    end

    always_comb begin
        pressed   = (state == DB_PRESSED) || (state == DB_DISARMING);
        press_evt = (state == DB_ARMING) && s && (cnt == DB_LAST);
        evt       = press_evt | rep_evt;
    end

    // Repeat timer runs only while PRESSED; it is held at zero through the press edge itself.
    if (REPEAT) begin : g_rep
        logic [REP_W-1:0] rcnt;
        logic             repeating;
        logic             rep_hit;

        assign rep_hit = (state == DB_PRESSED) &&
                         (rcnt == (repeating ? REP_W'(REP_PERIOD - 1) : REP_W'(REP_DELAY - 1)));
        assign rep_evt = rep_hit;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rcnt      <= '0;
                repeating <= 1'b0;
            end else if (state != DB_PRESSED) begin
                rcnt      <= '0;
                repeating <= 1'b0;
            end else if (rep_hit) begin
                rcnt      <= '0;
                repeating <= 1'b1;
            end else begin
                rcnt      <= rcnt + 1'b1;
            end
        end
    end else begin : g_norep
        assign rep_evt = 1'b0;
    end

endmodule

// File: rtl/btn_cmd_conditioner.sv
// rtl/btn_cmd_conditioner.sv - debounced buttons arbitrated into registered counter command pulses
module btn_cmd_conditioner
    import btn_cmd_conditioner_pkg::*;
#(
    parameter int DB_CYCLES  = 16,
    parameter int DB_W       = 5,
    parameter int REP_DELAY  = 1024,
    parameter int REP_PERIOD = 256,
    parameter int REP_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    btn_cmd_conditioner_if.slave  bus
);

    logic [CMD_NUM-1:0] evt;
    logic [CMD_NUM-1:0] pressed_unused;
    cmd_t               cmd;

    if ((DB_CYCLES < 2) || (DB_CYCLES >= 2**DB_W)) begin : g_bad_db
        $error("btn_cmd_conditioner: DB_CYCLES must be >= 2 and < 2**DB_W");
    end
    if ((REP_DELAY >= 2**REP_W) || (REP_PERIOD >= 2**REP_W) || (REP_PERIOD < 2)) begin : g_bad_rep
        $error("btn_cmd_conditioner: REP_DELAY/REP_PERIOD must fit REP_W, REP_PERIOD >= 2");
    end

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .REP_DELAY(REP_DELAY),
                   .REP_PERIOD(REP_PERIOD), .REP_W(REP_W), .REPEAT(1'b0))
    u_clr  (.clk(clk), .rst(rst), .raw(bus.btn_clr),
            .pressed(pressed_unused[CMD_CLR]), .evt(evt[CMD_CLR]));

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .REP_DELAY(REP_DELAY),
                   .REP_PERIOD(REP_PERIOD), .REP_W(REP_W), .REPEAT(1'b0))
    u_load (.clk(clk), .rst(rst), .raw(bus.btn_load),
            .pressed(pressed_unused[CMD_LOAD]), .evt(evt[CMD_LOAD]));

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .REP_DELAY(REP_DELAY),
                   .REP_PERIOD(REP_PERIOD), .REP_W(REP_W), .REPEAT(1'b1))
    u_inc  (.clk(clk), .rst(rst), .raw(bus.btn_inc),
            .pressed(pressed_unused[CMD_INC]), .evt(evt[CMD_INC]));

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .REP_DELAY(REP_DELAY),
                   .REP_PERIOD(REP_PERIOD), .REP_W(REP_W), .REPEAT(1'b1))
    u_dec  (.clk(clk), .rst(rst), .raw(bus.btn_dec),
            .pressed(pressed_unused[CMD_DEC]), .evt(evt[CMD_DEC]));

    assign cmd = arbitrate(evt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.en        <= 1'b0;
            bus.up        <= 1'b1;
            bus.load      <= 1'b0;
            bus.syn_clear <= 1'b0;
        end else begin
            bus.en        <= cmd.en;
            bus.up        <= cmd.up;
            bus.load      <= cmd.load;
            bus.syn_clear <= cmd.syn_clear;
        end
    end

endmodule
